// File: rtl/uart_calc_core.sv
// rtl/uart_calc_core.sv - ASCII hex calculator ("I S a+b=") over a byte-stream rx/tx interface
// Defining CALC_DIV_EN adds '/' through a sequential restoring divider.
module uart_calc_core #(
  parameter int DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err
);
  localparam int W   = 4 * DIGITS;
  localparam int R   = 2 * W;
  localparam int NCH = R / 4;

  typedef enum logic [3:0] {IDLE, SP1, MODE, SP2, OPA, OPB, CALC, DIV, TX, ERR_WAIT, TX_ERR} state_t;

  state_t       state;
  logic         sgn;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [3:0]   dcnt;
  logic [R-1:0] result;
  logic [5:0]   cnt;

  logic         is_hex, is_op, bad;
  logic [3:0]   hex_val;
  logic [1:0]   op_code;
  logic [R-1:0] ext_a, ext_b, calc_res;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  always_comb begin
    is_hex  = 1'b1;
    hex_val = rx_data[3:0];
    if (rx_data >= 8'h30 && rx_data <= 8'h39)
      hex_val = rx_data[3:0];
    else if ((rx_data >= 8'h41 && rx_data <= 8'h46) || (rx_data >= 8'h61 && rx_data <= 8'h66))
      hex_val = rx_data[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

  always_comb begin
    is_op   = 1'b1;
    op_code = 2'd0;
    case (rx_data)
      8'h2B: op_code = 2'd0;
      8'h2D: op_code = 2'd1;
      8'h2A: op_code = 2'd2;
`ifdef CALC_DIV_EN
      8'h2F: op_code = 2'd3;
`endif
      default: is_op = 1'b0;
    endcase
  end

  // Any byte the grammar cannot take in the current parse state
  always_comb begin
    bad = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE:     bad = (rx_data != 8'h49);
        SP1, SP2: bad = (rx_data != 8'h20);
        MODE:     bad = (rx_data != 8'h53) && (rx_data != 8'h55);
        OPA:      bad = is_hex ? (dcnt == 4'(DIGITS)) : !(is_op && dcnt != 4'd0);
        OPB:      bad = is_hex ? (dcnt == 4'(DIGITS)) : !(rx_data == 8'h3D && dcnt != 4'd0);
        default:  bad = 1'b0;
      endcase
    end
  end

  always_comb begin
    ext_a = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    ext_b = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    case (op)
      2'd0:    calc_res = ext_a + ext_b;
      2'd1:    calc_res = ext_a - ext_b;
      default: calc_res = ext_a * ext_b;
    endcase
  end

`ifdef CALC_DIV_EN
  logic [W-1:0] rem, quo, dvs, q_next, r_next, a_mag, b_mag;
  logic [W:0]   shifted, diff;
  logic         neg;
  logic [R-1:0] quot_res;

  // One restoring step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    shifted  = {rem, quo[W-1]};
    diff     = shifted - {1'b0, dvs};
    r_next   = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    q_next   = (quo << 1) | W'(!diff[W]);
    a_mag    = (sgn && a[W-1]) ? -a : a;
    b_mag    = (sgn && b[W-1]) ? -b : b;
    quot_res = neg ? -{{W{1'b0}}, q_next} : {{W{1'b0}}, q_next};
  end
`endif

  assign busy = (state == CALC) || (state == DIV) || (state == TX) || (state == TX_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sgn      <= 1'b0;
      op       <= 2'd0;
      a        <= '0;
      b        <= '0;
      dcnt     <= 4'd0;
      result   <= '0;
      cnt      <= 6'd0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      err      <= 1'b0;
`ifdef CALC_DIV_EN
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg      <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      if (bad) begin
        err <= 1'b1;
        if (rx_data == 8'h3D) begin
          tx_valid <= 1'b1;
          tx_data  <= 8'h45;
          cnt      <= 6'd0;
          state    <= TX_ERR;
        end else begin
          state <= ERR_WAIT;
        end
      end else begin
        case (state)
          IDLE: if (rx_valid) state <= SP1;
          SP1:  if (rx_valid) state <= MODE;
          MODE: if (rx_valid) begin
            sgn   <= (rx_data == 8'h53);
            state <= SP2;
          end
          SP2: if (rx_valid) begin
            a     <= '0;
            dcnt  <= 4'd0;
            state <= OPA;
          end
          OPA: if (rx_valid) begin
            if (is_hex) begin
              a    <= (a << 4) | W'(hex_val);
              dcnt <= dcnt + 4'd1;
            end else begin
              op    <= op_code;
              b     <= '0;
              dcnt  <= 4'd0;
              state <= OPB;
            end
          end
          OPB: if (rx_valid) begin
            if (is_hex) begin
              b    <= (b << 4) | W'(hex_val);
              dcnt <= dcnt + 4'd1;
            end else begin
              state <= CALC;
            end
          end
          CALC: begin
`ifdef CALC_DIV_EN
            if (op == 2'd3) begin
              if (b == '0) begin
                err      <= 1'b1;
                tx_valid <= 1'b1;
                tx_data  <= 8'h45;
                cnt      <= 6'd0;
                state    <= TX_ERR;
              end else begin
                rem   <= '0;
                quo   <= a_mag;
                dvs   <= b_mag;
                neg   <= sgn & (a[W-1] ^ b[W-1]);
                cnt   <= 6'd0;
                state <= DIV;
              end
            end else
`endif
            begin
              tx_valid <= 1'b1;
              tx_data  <= hex_char(calc_res[R-1 -: 4]);
              result   <= calc_res << 4;
              cnt      <= 6'd0;
              state    <= TX;
            end
          end
`ifdef CALC_DIV_EN
          DIV: begin
            rem <= r_next;
            quo <= q_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'(W - 1)) begin
              tx_valid <= 1'b1;
              tx_data  <= hex_char(quot_res[R-1 -: 4]);
              result   <= quot_res << 4;
              cnt      <= 6'd0;
              state    <= TX;
            end
          end
`endif
          ERR_WAIT: if (rx_valid && rx_data == 8'h3D) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h45;
            cnt      <= 6'd0;
            state    <= TX_ERR;
          end
          // cnt counts bytes already accepted; result holds the not-yet-sent nibbles
          TX: if (tx_ready) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(NCH + 1)) begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              state    <= IDLE;
            end else if (cnt == 6'(NCH)) begin
              tx_data <= 8'h0A;
            end else if (cnt == 6'(NCH - 1)) begin
              tx_data <= 8'h0D;
            end else begin
              tx_data <= hex_char(result[R-1 -: 4]);
              result  <= result << 4;
            end
          end
          TX_ERR: if (tx_ready) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd2) begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              state    <= IDLE;
            end else if (cnt == 6'd1) begin
              tx_data <= 8'h0A;
            end else begin
              tx_data <= 8'h0D;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_calc_core.sv
// tb/tb_uart_calc_core.sv - directed self-checking bench for uart_calc_core (DIGITS=4)
module tb_uart_calc_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       err;

  int    checks = 0;
  int    errors = 0;
  string crlf;

  always #5 clk = ~clk;

  uart_calc_core #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err)
  );

  function automatic string vis(input string s);
    string o = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D) o = {o, "<CR>"};
      else if (s[i] == 8'h0A) o = {o, "<LF>"};
      else o = $sformatf("%s%c", o, s[i]);
    end
    return o;
  endfunction

  // All tasks are entered and left at a falling edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic get_resp(output string s, output int lat, output bit tmo);
    int n = 0;
    s = "";
    lat = 0;
    tmo = 1'b0;
    while (!tx_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    while (n < 100) begin
      if (tx_valid && tx_ready) begin
        s = $sformatf("%s%c", s, tx_data);
        if (tx_data == 8'h0A) begin
          @(negedge clk);
          return;
        end
      end
      @(negedge clk);
      n++;
    end
    tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    string s; int lat; bit tmo;
    send_str("I S fff5+fff5=");
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy got %b want 1", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL add_calc_txv got %b want 0", tx_valid); end
    get_resp(s, lat, tmo);
    checks++; if (lat != 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    checks++; if (tmo || s != {"FFFFFFEA", crlf}) begin errors++; $display("FAIL add_result got %s want FFFFFFEA<CR><LF>", vis(s)); end
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL add_idle got busy=%b txv=%b want 0 0", busy, tx_valid); end
  endtask

  task automatic test_mul();
    string s; int lat; bit tmo;
    send_str("I U ffff*ffff=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"FFFE0001", crlf}) begin errors++; $display("FAIL mul_unsigned got %s want FFFE0001<CR><LF>", vis(s)); end
    send_str("I S fffe*3=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"FFFFFFFA", crlf}) begin errors++; $display("FAIL mul_signed got %s want FFFFFFFA<CR><LF>", vis(s)); end
    send_str("I U A*b=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"0000006E", crlf}) begin errors++; $display("FAIL mul_case got %s want 0000006E<CR><LF>", vis(s)); end
  endtask

  task automatic test_back_to_back();
    string s; int lat; bit tmo;
    send_str("I U 1+2=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"00000003", crlf}) begin errors++; $display("FAIL b2b_first got %s want 00000003<CR><LF>", vis(s)); end
    send_str("I S 8000-1=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"FFFF7FFF", crlf}) begin errors++; $display("FAIL b2b_signed_sub got %s want FFFF7FFF<CR><LF>", vis(s)); end
    send_str("I U 0-1=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"FFFFFFFF", crlf}) begin errors++; $display("FAIL b2b_unsigned_sub got %s want FFFFFFFF<CR><LF>", vis(s)); end
  endtask

  task automatic test_errors();
    string s; int lat; bit tmo;
    send_str("I ");
    send_byte("X");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_mode_pulse got %b want 1", err); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_mode_single got %b want 0", err); end
    send_str(" 1+2");
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL err_early_tx got %b want 0", tx_valid); end
    send_byte("=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"E", crlf}) begin errors++; $display("FAIL err_mode_resp got %s want E<CR><LF>", vis(s)); end
    send_str("I U 1234");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_4digit got %b want 0", err); end
    send_byte("5");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_5th_digit got %b want 1", err); end
    send_str("+1=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"E", crlf}) begin errors++; $display("FAIL err_digit_resp got %s want E<CR><LF>", vis(s)); end
    send_str("I U ");
    send_byte("+");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_no_digits got %b want 1", err); end
    send_str("=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"E", crlf}) begin errors++; $display("FAIL err_no_digits_resp got %s want E<CR><LF>", vis(s)); end
`ifndef CALC_DIV_EN
    send_str("I U 5");
    send_byte("/");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_div_disabled got %b want 1", err); end
    send_str("2=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"E", crlf}) begin errors++; $display("FAIL err_div_disabled_resp got %s want E<CR><LF>", vis(s)); end
`endif
  endtask

`ifdef CALC_DIV_EN
  task automatic test_div();
    string s; int lat; bit tmo;
    send_str("I U fff4/0004=");
    get_resp(s, lat, tmo);
    checks++; if (lat != 17) begin errors++; $display("FAIL div_latency got %0d want 17", lat); end
    checks++; if (tmo || s != {"00003FFD", crlf}) begin errors++; $display("FAIL div_unsigned got %s want 00003FFD<CR><LF>", vis(s)); end
    send_str("I S fff8/3=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"FFFFFFFE", crlf}) begin errors++; $display("FAIL div_signed got %s want FFFFFFFE<CR><LF>", vis(s)); end
    send_str("I U 5/0=");
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL div_zero_err got %b want 1", err); end
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"E", crlf}) begin errors++; $display("FAIL div_zero_resp got %s want E<CR><LF>", vis(s)); end
  endtask
`endif

  task automatic test_stall();
    string got = "";
    string rest, junk;
    int lat, n;
    bit tmo, unstable, saw_err, not_busy;
    logic [7:0] held;
    junk = "I U 1+1=";
    unstable = 1'b0; saw_err = 1'b0; not_busy = 1'b0;
    send_str("I U 1234+1111=");
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      got = $sformatf("%s%c", got, tx_data);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    held = tx_data;
    checks++; if (held !== 8'h32) begin errors++; $display("FAIL stall_held got %h want 32", held); end
    for (int i = 0; i < 20; i++) begin
      rx_data  = junk[i % 8];
      rx_valid = 1'b1;
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== held) unstable = 1'b1;
      if (err) saw_err = 1'b1;
      if (!busy) not_busy = 1'b1;
    end
    rx_valid = 1'b0;
    checks++; if (unstable) begin errors++; $display("FAIL stall_stable got changed want %h held", held); end
    checks++; if (saw_err || not_busy) begin errors++; $display("FAIL stall_drop got err=%b notbusy=%b want 0 0", saw_err, not_busy); end
    tx_ready = 1'b1;
    get_resp(rest, lat, tmo);
    got = {got, rest};
    checks++; if (tmo || got != {"00002345", crlf}) begin errors++; $display("FAIL stall_result got %s want 00002345<CR><LF>", vis(got)); end
    send_str("I U 2+2=");
    get_resp(rest, lat, tmo);
    checks++; if (tmo || rest != {"00000004", crlf}) begin errors++; $display("FAIL stall_after got %s want 00000004<CR><LF>", vis(rest)); end
  endtask

  task automatic test_reset_mid();
    string s; int lat, n; bit tmo, stray;
    stray = 1'b0;
    send_str("I U 1234+1111=");
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_state got busy=%b data=%h want 0 00", busy, tx_data); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx_valid) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("FAIL rstmid_partial got tx_valid want none"); end
    send_str("I S fffe*3=");
    get_resp(s, lat, tmo);
    checks++; if (tmo || s != {"FFFFFFFA", crlf}) begin errors++; $display("FAIL rstmid_next got %s want FFFFFFFA<CR><LF>", vis(s)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    crlf = $sformatf("%c%c", 8'h0D, 8'h0A);
    @(negedge clk);
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_errors();
`ifdef CALC_DIV_EN
    test_div();
`endif
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
